arduino_move_rx: RTL
====================

# arduino_move_rx

Serial move receiver for the Connect4 datapath. It deserialises UART bytes sent by the Arduino player, checks that each byte is a legal column character, and produces the `column` value and single-cycle `load` strobe that the game controller and column loader consume. It is the sending side of the `column`/`load` interface, and replaces the push-button path when the Arduino is on turn.

## Interface
Parameters:
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `BAUD`, default 9600: serial bit rate.
- `NUM_COLS`, default 7: number of legal columns. Must be ≤ 8.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `rx`, input, 1: UART line from the Arduino. Idle-high and asynchronous to `clk`.
- `arduino_turn`, input, 1: high when the Arduino player is allowed to move.
- `column`, output, 3: last accepted column, 0..NUM_COLS-1.
- `load`, output, 1: one-cycle strobe marking a newly accepted `column`.
- `reject`, output, 1: one-cycle strobe for a well-framed byte that was discarded.
- `frame_err`, output, 1: one-cycle strobe for a bad stop bit (or bad parity, see Configuration).

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- Derived constants:
  - BIT = CLK_HZ/BAUD (integer division, truncated).
  - HALF = BIT/2.
- FSM states are IDLE, START, DATA, PARITY, STOP and EMIT.
  - IDLE: a synchronised 1→0 edge loads the timer with HALF and moves to START.
  - START: when the timer expires, resample the line.
    - Line low: move to DATA with a bit index of 0 and the timer at BIT.
    - Line high: treat as a false start and return to IDLE with no strobe.
  - DATA: sample on each timer expiry and shift in LSB first. After bit 7, go to PARITY if the macro is defined, otherwise to STOP.
  - STOP: sample on timer expiry.
    - Sample 0: pulse `frame_err` and go to IDLE.
    - Sample 1: go to EMIT.
  - EMIT: lasts exactly one cycle, then always returns to IDLE.
    - The byte is valid when it lies in 8'h30 .. 8'h30+NUM_COLS-1 (ASCII '0'..).
    - Valid byte with `arduino_turn`=1 (sampled in EMIT): set `column` = byte[2:0] and pulse `load`.
    - Any other case: pulse `reject` and leave `column` unchanged.
- `column` holds its value until the next accepted move.
- At most one of `load`, `reject` and `frame_err` is high in any cycle.
- Reset, asserted at any time including mid-byte:
  - FSM returns to IDLE, with the timer and shift register cleared.
  - `column`=0, `load`=0, `reject`=0, `frame_err`=0.
- A new start edge is only seen from IDLE. A falling edge during EMIT is detected on the following cycle.

## Timing
- All outputs are registered.
- Falling edge of the `rx` pin → `load` rising edge:
  - 8N1: 2 + HALF + 9·BIT + 1 cycles, with ±1 cycle of synchroniser uncertainty.
  - With parity: 2 + HALF + 10·BIT + 1 cycles.
- Strobe width is exactly 1 cycle.
- Back-to-back bytes with zero idle time after the stop bit are received without loss.

## Configuration
- `ARDUINO_RX_PARITY_EN` defined:
  - Frame format is 8E1, and the PARITY state exists.
  - The PARITY state samples one extra bit.
  - If the XOR of the 8 data bits and the parity bit is 1, pulse `frame_err` after the stop-bit sample and do not enter EMIT.
- Macro undefined:
  - Frame format is 8N1.
  - The PARITY state and its logic are not compiled.

## Structure
- Shared package `connect4_pkg` holds:
  - the FSM state enum,
  - `ASCII_ZERO` = 8'h30,
  - the frame-length constants.
- One sub-module, `bit_timer`:
  - a down-counter with a synchronous load value (HALF or BIT) and an `expire` pulse,
  - width $clog2(BIT+1),
  - same asynchronous active-low reset.

## Test plan
Simulation settings: CLK_HZ=16, BAUD=1, so BIT=16 and HALF=8.
- Send 8'h33 with `arduino_turn`=1 → `column`=3 and `load` high for 1 cycle at edge+155±1. `reject` and `frame_err` stay 0.
- Send 8'h37, then 8'h41, with `arduino_turn`=1 → one `reject` pulse per byte, no `load`, and `column` stays 3.
- Send 8'h31 with `arduino_turn`=0 → `reject` pulse and `column` unchanged. Repeat with `arduino_turn`=1 → `column`=1 and `load` pulses.
- Send 8'h32 with stop bit driven 0 → `frame_err` pulse and no `load`. An immediately following 8'h30 → `column`=0 and `load` pulses.
- Drive `rx` low for 4 cycles, then high → no strobes, and the FSM is back in IDLE. A subsequent 8'h34 is received correctly.
- Assert `rst` during data bit 4 of 8'h35 → all outputs are 0 on the next edge and no `load` occurs. After release, 8'h36 → `column`=6.
- With `ARDUINO_RX_PARITY_EN`: 8'h33 with wrong parity → `frame_err`. With correct parity → `load` at edge+171±1.

Source files
------------

// File: rtl/connect4_pkg.sv
// Shared definitions for the Connect4 serial move receiver.
//   rx_state_t      : receiver FSM state encoding
//   ASCII_ZERO      : character code of column 0 ('0')
//   DATA_BITS, FRAME_BITS_8N1, FRAME_BITS_8E1 : frame-length constants
package connect4_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_EMIT   = 3'd5
  } rx_state_t;

  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  localparam int         DATA_BITS      = 8;
  localparam int         FRAME_BITS_8N1 = 10;
  localparam int         FRAME_BITS_8E1 = 11;

endpackage

// File: rtl/arduino_move_rx_bit_timer.sv
// bit_timer: down-counter that paces the UART bit sampling.
//   clk, rst      : clock, asynchronous active-low reset (counter cleared)
//   load          : synchronously load load_val (wins over counting)
//   load_val[W-1:0]: cycles until the next expire pulse
//   expire        : high for one cycle, exactly load_val cycles after a load
// A counter at zero stays at zero and never expires.
module bit_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // The FSM acts on the edge that ends the cycle where the count reads 1,
  // i.e. exactly load_val edges after the load edge.
  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/arduino_move_rx.sv
// arduino_move_rx: UART move receiver for the Connect4 datapath.
// Deserialises bytes from the Arduino player and turns legal column
// characters ('0'..'0'+NUM_COLS-1) into a column value plus load strobe.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   rx           : idle-high UART line, asynchronous to clk
//   arduino_turn : Arduino may move; sampled when a byte completes
//   column[2:0]  : last accepted column (held until the next accept)
//   load         : 1-cycle strobe, new column accepted
//   reject       : 1-cycle strobe, well-framed byte discarded
//   frame_err    : 1-cycle strobe, bad stop bit (or bad parity)
//   dbg_state    : current receiver FSM state
// Build option: define ARDUINO_RX_PARITY_EN for 8E1 frames (default 8N1).
// Strobe handshake: load/reject/frame_err are single-cycle, mutually
// exclusive pulses with no back-pressure; the consumer must take column on
// the cycle load is high.
module arduino_move_rx
  import connect4_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int NUM_COLS = 7
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  input  logic      arduino_turn,
  output logic [2:0] column,
  output logic      load,
  output logic      reject,
  output logic      frame_err,
  output rx_state_t dbg_state
);

  localparam int BIT_CYCLES  = CLK_HZ / BAUD;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int TW          = $clog2(BIT_CYCLES + 1);
  localparam logic [7:0] MAX_CHAR = ASCII_ZERO + 8'(NUM_COLS - 1);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic      rx_meta_q, rx_sync_q, rx_prev_q, rx_prev_d;
  rx_state_t state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] column_q, column_d;
  logic      load_q, load_d, reject_q, reject_d, frame_err_q, frame_err_d;
  logic          tmr_load, tmr_expire;
  logic [TW-1:0] tmr_val;
  logic          byte_valid;
`ifdef ARDUINO_RX_PARITY_EN
  logic      par_q, par_d;  // running XOR of data and parity bits
`endif

  bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign byte_valid = (shift_q >= ASCII_ZERO) && (shift_q <= MAX_CHAR);

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    column_d    = column_q;
    load_d      = 1'b0;
    reject_d    = 1'b0;
    frame_err_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = TW'(BIT_CYCLES);
    // Hold the previous line level through EMIT so a start edge that lands
    // there is still seen as a 1->0 transition once back in IDLE.
    rx_prev_d   = (state_q == S_EMIT) ? rx_prev_q : rx_sync_q;
`ifdef ARDUINO_RX_PARITY_EN
    par_d       = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(HALF_CYCLES);
          state_d  = S_START;
        end
      end
      S_START: begin
        if (tmr_expire) begin
          if (!rx_sync_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
            tmr_load  = 1'b1;
`ifdef ARDUINO_RX_PARITY_EN
            par_d     = 1'b0;
`endif
          end else begin
            state_d = S_IDLE;  // glitch, not a real start bit
          end
        end
      end
      S_DATA: begin
        if (tmr_expire) begin
          shift_d  = {rx_sync_q, shift_q[7:1]};  // LSB arrives first
          tmr_load = 1'b1;
`ifdef ARDUINO_RX_PARITY_EN
          par_d    = par_q ^ rx_sync_q;
`endif
          if (bit_idx_q == LAST_IDX) begin
`ifdef ARDUINO_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef ARDUINO_RX_PARITY_EN
      S_PARITY: begin
        if (tmr_expire) begin
          par_d    = par_q ^ rx_sync_q;
          tmr_load = 1'b1;
          state_d  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tmr_expire) begin
`ifdef ARDUINO_RX_PARITY_EN
          if (!rx_sync_q || par_q) begin
`else
          if (!rx_sync_q) begin
`endif
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        state_d = S_IDLE;
        if (byte_valid && arduino_turn) begin
          column_d = shift_q[2:0];
          load_d   = 1'b1;
        end else begin
          reject_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      column_q    <= '0;
      load_q      <= 1'b0;
      reject_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef ARDUINO_RX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      column_q    <= column_d;
      load_q      <= load_d;
      reject_q    <= reject_d;
      frame_err_q <= frame_err_d;
`ifdef ARDUINO_RX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign column    = column_q;
  assign load      = load_q;
  assign reject    = reject_q;
  assign frame_err = frame_err_q;
  assign dbg_state = state_q;

endmodule
